// File: rtl/keypoint_scan_ctrl_if.sv
// keypoint_scan_ctrl_if
//   Keypoint SRAM write bus driven by the scan controller, one lane per DoG scale.
//   kp_we        per-scale write strobe (one cycle per accepted keypoint)
//   kp_addr      packed per-scale write address, scale s in slice s
//   kp_din       packed per-scale write data {row, col}, scale s in slice s
//   kp_overflow  sticky per-scale "SRAM full" flag
//   master: the scan controller; slave: the keypoint SRAMs / observers.
interface keypoint_scan_ctrl_if #(
    parameter int NUM_SCALES = 2,
    parameter int KP_AW      = 11,
    parameter int ROW_W      = 9,
    parameter int COL_W      = 10
);
    logic [NUM_SCALES-1:0]               kp_we;
    logic [NUM_SCALES*KP_AW-1:0]         kp_addr;
    logic [NUM_SCALES*(ROW_W+COL_W)-1:0] kp_din;
    logic [NUM_SCALES-1:0]               kp_overflow;

    modport master (output kp_we, kp_addr, kp_din, kp_overflow);
    modport slave  (input  kp_we, kp_addr, kp_din, kp_overflow);
endinterface

// File: rtl/keypoint_scan_ctrl.sv
// keypoint_scan_ctrl
//   Walks a frame row by row and column by column (border excluded), hands the
//   current column to the extremum/filter units and writes {row, col} of every
//   accepted keypoint into a per-scale keypoint SRAM.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     start, abort    begin a scan (IDLE only) / terminate it (any busy state)
//     busy, done      not-IDLE flag, one-cycle frame-complete pulse
//     row_addr        row address shared by the blur/image SRAMs
//     buffer_we       line-buffer shift strobe
//     current_col     column under test
//     is_keypoint     per-scale extremum flag for current_col
//     valid_keypoint  per-scale edge/contrast pass flag
//     kp_count        (KP_COUNT_EN only) per-scale accepted-write totals
//     kp_bus          keypoint SRAM write bus (master side)
//   Optional feature: define KP_COUNT_EN to add the kp_count output.
module keypoint_scan_ctrl #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int NUM_SCALES = 2,
    parameter int KP_AW      = 11,
    parameter int ROW_W      = 9,
    parameter int COL_W      = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic [ROW_W-1:0]       row_addr,
    output logic                   buffer_we,
    output logic [COL_W-1:0]       current_col,
    input  logic [NUM_SCALES-1:0]  is_keypoint,
    input  logic [NUM_SCALES-1:0]  valid_keypoint,
`ifdef KP_COUNT_EN
    output logic [NUM_SCALES*(KP_AW+1)-1:0] kp_count,
`endif
    keypoint_scan_ctrl_if.master   kp_bus
);
    localparam int                 DW        = ROW_W + COL_W;
    localparam logic [ROW_W-1:0]   LAST_ROW  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0]   LAST_COL  = COL_W'(IMG_W - 2);
    localparam logic [COL_W-1:0]   FIRST_COL = COL_W'(1);
    localparam logic [KP_AW-1:0]   ADDR_MAX  = {KP_AW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE, S_READY, S_DETECT, S_FILTER, S_UPDATE, S_BUFFER, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   ready2_q, ready2_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   buffer_we_q, buffer_we_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [NUM_SCALES-1:0]  kp_we_q;
    logic [NUM_SCALES-1:0]  kp_ovf_vec;
    logic [NUM_SCALES-1:0]  kp_accept;
    logic                   abort_hit;
    logic                   clear_kp;

    assign abort_hit = abort && (state_q != S_IDLE);
    assign clear_kp  = (state_q == S_IDLE) && start;
    // A write decided in FILTER is issued next cycle; an abort in the same
    // cycle kills it before it reaches the strobe register.
    assign kp_accept = (state_q == S_FILTER && !abort_hit) ?
                       (valid_keypoint & ~kp_ovf_vec) : '0;

    always_comb begin
        state_d     = state_q;
        ready2_d    = ready2_q;
        row_d       = row_q;
        col_d       = col_q;
        buffer_we_d = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_READY;
                    ready2_d    = 1'b0;
                    row_d       = ROW_W'(1);
                    col_d       = FIRST_COL;
                    buffer_we_d = 1'b1;   // visible during the first READY cycle
                end
            end
            S_READY: begin
                if (!ready2_q) ready2_d = 1'b1;
                else           state_d  = S_DETECT;
            end
            S_DETECT: begin
                if (|is_keypoint)            state_d = S_FILTER;
                else if (col_q == LAST_COL)  state_d = S_UPDATE;
                else                         col_d   = col_q + 1'b1;
            end
            S_FILTER: begin
                if (col_q == LAST_COL) begin
                    state_d = S_UPDATE;
                end else begin
                    col_d   = col_q + 1'b1;
                    state_d = S_DETECT;
                end
            end
            S_UPDATE: begin
                col_d = FIRST_COL;
                if (row_q == LAST_ROW) begin
                    state_d = S_DONE;
                end else begin
                    row_d       = row_q + 1'b1;
                    state_d     = S_BUFFER;
                    buffer_we_d = 1'b1;   // visible during the BUFFER cycle
                end
            end
            S_BUFFER: state_d = S_DETECT;
            S_DONE: begin
                done_d  = 1'b1;
                row_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_hit) begin
            state_d     = S_IDLE;
            row_d       = '0;
            col_d       = FIRST_COL;
            buffer_we_d = 1'b0;
            done_d      = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ready2_q    <= 1'b0;
            row_q       <= '0;
            col_q       <= FIRST_COL;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            buffer_we_q <= 1'b0;
            kp_we_q     <= '0;
        end else begin
            state_q     <= state_d;
            ready2_q    <= ready2_d;
            row_q       <= row_d;
            col_q       <= col_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            buffer_we_q <= buffer_we_d;
            kp_we_q     <= kp_accept;
        end
    end

    // Per-scale write address, overflow flag and captured data.
    generate
        for (genvar gi = 0; gi < NUM_SCALES; gi++) begin : g_scale
            logic [KP_AW-1:0] addr_q, addr_d;
            logic             ovf_q, ovf_d;
            logic [DW-1:0]    din_q, din_d;

            always_comb begin
                addr_d = addr_q;
                ovf_d  = ovf_q;
                din_d  = din_q;
                if (clear_kp) begin
                    addr_d = '0;
                    ovf_d  = 1'b0;
                end else if (kp_we_q[gi]) begin
                    // The last slot has just been written: flag full and hold.
                    if (addr_q == ADDR_MAX) ovf_d  = 1'b1;
                    else                    addr_d = addr_q + 1'b1;
                end
                if (kp_accept[gi]) din_d = {row_q, col_q};
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    addr_q <= '0;
                    ovf_q  <= 1'b0;
                    din_q  <= '0;
                end else begin
                    addr_q <= addr_d;
                    ovf_q  <= ovf_d;
                    din_q  <= din_d;
                end
            end

`ifdef KP_COUNT_EN
            // No write can occur after DONE, so the total stays frozen there.
            logic [KP_AW:0] cnt_q, cnt_d;
            always_comb begin
                cnt_d = cnt_q;
                if (clear_kp)          cnt_d = '0;
                else if (kp_we_q[gi])  cnt_d = cnt_q + 1'b1;
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end
            assign kp_count[gi*(KP_AW+1) +: (KP_AW+1)] = cnt_q;
`endif

            assign kp_ovf_vec[gi]               = ovf_q;
            assign kp_bus.kp_addr[gi*KP_AW +: KP_AW] = addr_q;
            assign kp_bus.kp_din[gi*DW +: DW]   = din_q;
        end
    endgenerate

    assign busy               = busy_q;
    assign done               = done_q;
    assign row_addr           = row_q;
    assign buffer_we          = buffer_we_q;
    assign current_col        = col_q;
    assign kp_bus.kp_we       = kp_we_q;
    assign kp_bus.kp_overflow = kp_ovf_vec;
endmodule

// File: tb/tb_keypoint_scan_ctrl.sv
// tb_keypoint_scan_ctrl
//   Drives keypoint_scan_ctrl on an 8x4 image with 2 scales and 4-entry
//   keypoint SRAMs. Detect/filter units are modelled by per-pixel tables
//   looked up with the DUT's row/column; a frame-level model derives the
//   expected done latency and the ordered list of SRAM writes.
module tb_keypoint_scan_ctrl;
    localparam int W   = 8;
    localparam int H   = 4;
    localparam int NS  = 2;
    localparam int AW  = 2;
    localparam int RW  = 9;
    localparam int CW  = 10;
    localparam int DW  = RW + CW;
    localparam int CAP = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done, buffer_we;
    logic [RW-1:0] row_addr;
    logic [CW-1:0] current_col;
    logic [NS-1:0] is_keypoint, valid_keypoint;
`ifdef KP_COUNT_EN
    logic [NS*(AW+1)-1:0] kp_count;
`endif

    keypoint_scan_ctrl_if #(.NUM_SCALES(NS), .KP_AW(AW), .ROW_W(RW), .COL_W(CW)) kp_bus ();

    keypoint_scan_ctrl #(
        .IMG_W(W), .IMG_H(H), .NUM_SCALES(NS), .KP_AW(AW), .ROW_W(RW), .COL_W(CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .row_addr       (row_addr),
        .buffer_we      (buffer_we),
        .current_col    (current_col),
        .is_keypoint    (is_keypoint),
        .valid_keypoint (valid_keypoint),
`ifdef KP_COUNT_EN
        .kp_count       (kp_count),
`endif
        .kp_bus         (kp_bus)
    );

    always #5 clk = ~clk;

    // Pixel tables standing in for the extremum and filter units.
    logic [1:0] tab_kp [0:3][0:7];
    logic [1:0] tab_vk [0:3][0:7];
    assign is_keypoint    = tab_kp[row_addr[1:0]][current_col[2:0]];
    assign valid_keypoint = tab_vk[row_addr[1:0]][current_col[2:0]];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int n_buf = 0, n_done = 0, done_cyc = 0;
    logic [63:0] wr_q  [$];
    logic [63:0] exp_q [$];
    int exp_n [NS];
    int exp_lat;

    function automatic logic [63:0] pack_wr(input int s, input int addr, input int row, input int col);
        logic [63:0] v;
        v = '0;
        v[63:56] = 8'(s);
        v[55:48] = 8'(addr);
        v[47:32] = 16'(row);
        v[15:0]  = 16'(col);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [DW-1:0] d;
        if (buffer_we === 1'b1) n_buf++;
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
        for (int s = 0; s < NS; s++) begin
            if (kp_bus.kp_we[s] === 1'b1) begin
                d = kp_bus.kp_din[s*DW +: DW];
                wr_q.push_back(pack_wr(s, int'(kp_bus.kp_addr[s*AW +: AW]),
                                       int'(d[DW-1:CW]), int'(d[CW-1:0])));
            end
        end
    end

    // Frame model: 2 READY cycles, per row one cycle per column plus one extra
    // per keypoint column plus UPDATE, a BUFFER between rows, DONE, then done
    // is seen one cycle later. Writes go out in scan order, at most CAP per scale.
    task automatic model_frame();
        exp_q.delete();
        for (int s = 0; s < NS; s++) exp_n[s] = 0;
        exp_lat = 2 + (H - 2) + 1;
        for (int r = 1; r < H; r++) begin
            exp_lat += 1;
            for (int c = 1; c <= W - 2; c++) begin
                exp_lat += 1;
                if (tab_kp[r][c] != 2'b00) begin
                    exp_lat += 1;
                    for (int s = 0; s < NS; s++) begin
                        if (tab_vk[r][c][s] && exp_n[s] < CAP) begin
                            exp_q.push_back(pack_wr(s, exp_n[s], r, c));
                            exp_n[s]++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic clear_tables();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++) begin
                tab_kp[r][c] = 2'b00;
                tab_vk[r][c] = 2'b00;
            end
    endtask

    task automatic random_tables();
        clear_tables();
        for (int r = 1; r < H; r++)
            for (int c = 1; c <= W - 2; c++) begin
                tab_kp[r][c] = ($urandom_range(0, 99) < 30) ? 2'($urandom_range(1, 3)) : 2'b00;
                tab_vk[r][c] = 2'($urandom_range(0, 3));
            end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        n_buf = 0; n_done = 0; done_cyc = 0;
        wr_q.delete();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_done != 0) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_pos(input int r, input int c, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (int'(row_addr) == r && int'(current_col) == c) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_frame(input string name, input bit poke);
        bit seen;
        int ea;
        model_frame();
        pulse_start();
        chk({name, "/start_row"}, row_addr, 1);
        chk({name, "/start_col"}, current_col, 1);
        chk({name, "/start_busy"}, busy, 1);
        chk({name, "/start_bwe"}, buffer_we, 1);
        chk({name, "/start_addr"}, kp_bus.kp_addr, 0);
        chk({name, "/start_ovf"}, kp_bus.kp_overflow, 0);
        if (poke) begin
            repeat (10) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(300, seen);
        chk({name, "/done_seen"}, seen, 1);
        repeat (3) @(negedge clk);
        chk({name, "/latency"}, done_cyc - start_cyc, exp_lat);
        chk({name, "/done_pulses"}, n_done, 1);
        chk({name, "/buffer_we_pulses"}, n_buf, H - 1);
        chk({name, "/busy_end"}, busy, 0);
        chk({name, "/n_writes"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            chk($sformatf("%s/wr%0d", name, i), wr_q[i], exp_q[i]);
        for (int s = 0; s < NS; s++) begin
            ea = (exp_n[s] == CAP) ? CAP - 1 : exp_n[s];
            chk($sformatf("%s/addr%0d", name, s), kp_bus.kp_addr[s*AW +: AW], ea);
            chk($sformatf("%s/ovf%0d", name, s), kp_bus.kp_overflow[s], (exp_n[s] == CAP) ? 1 : 0);
`ifdef KP_COUNT_EN
            chk($sformatf("%s/count%0d", name, s), kp_count[s*(AW+1) +: (AW+1)], exp_n[s]);
`endif
        end
        $display("frame %s: latency %0d (model %0d), %0d writes (model %0d)",
                 name, done_cyc - start_cyc, exp_lat, wr_q.size(), exp_q.size());
    endtask

    initial begin
        bit seen;
        clear_tables();

        // Reset state, checked while reset is held.
        #1 rst_n = 1'b0;
        #1;
        chk("reset/ctrl", {busy, done, buffer_we}, 0);
        chk("reset/row", row_addr, 0);
        chk("reset/col", current_col, 1);
        chk("reset/kp_we", kp_bus.kp_we, 0);
        chk("reset/kp_addr", kp_bus.kp_addr, 0);
        chk("reset/kp_din", kp_bus.kp_din, 0);
        chk("reset/ovf", kp_bus.kp_overflow, 0);
`ifdef KP_COUNT_EN
        chk("reset/count", kp_count, 0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle/busy", busy, 0);
        chk("idle/row", row_addr, 0);

        // Empty frame, with a start pulse mid-scan that must be ignored.
        do_frame("empty", 1'b1);

        // Single scale-0 keypoint at row 2, col 3.
        clear_tables();
        tab_kp[2][3] = 2'b01;
        tab_vk[2][3] = 2'b01;
        do_frame("single", 1'b0);

        // Five scale-1 keypoints: four writes, then full.
        clear_tables();
        tab_kp[1][2] = 2'b10; tab_vk[1][2] = 2'b10;
        tab_kp[1][5] = 2'b10; tab_vk[1][5] = 2'b10;
        tab_kp[2][1] = 2'b10; tab_vk[2][1] = 2'b10;
        tab_kp[3][3] = 2'b10; tab_vk[3][3] = 2'b10;
        tab_kp[3][6] = 2'b10; tab_vk[3][6] = 2'b10;
        do_frame("overflow", 1'b0);
        repeat (5) @(negedge clk);
        chk("retain/ovf", kp_bus.kp_overflow, 2'b10);
        chk("retain/addr1", kp_bus.kp_addr[2*AW-1:AW], 3);

        // Randomized frames.
        for (int k = 0; k < 6; k++) begin
            random_tables();
            do_frame($sformatf("rand%0d", k), k == 2);
        end

        // Abort during row 2 DETECT, after one scale-0 write in row 1.
        clear_tables();
        tab_kp[1][2] = 2'b01;
        tab_vk[1][2] = 2'b01;
        pulse_start();
        wait_pos(2, 3, 200, seen);
        chk("abort/reach", seen, 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort/busy", busy, 0);
        chk("abort/row", row_addr, 0);
        chk("abort/col", current_col, 1);
        chk("abort/addr0", kp_bus.kp_addr[AW-1:0], 1);
        repeat (30) @(negedge clk);
        chk("abort/no_done", n_done, 0);
        chk("abort/idle", busy, 0);
        chk("abort/addr0_kept", kp_bus.kp_addr[AW-1:0], 1);
        clear_tables();
        do_frame("restart", 1'b0);

        // Reset asserted in FILTER with writes pending on both scales.
        clear_tables();
        tab_kp[1][4] = 2'b11;
        tab_vk[1][4] = 2'b11;
        pulse_start();
        wait_pos(1, 4, 200, seen);
        chk("rst/reach", seen, 1);
        @(negedge clk);
        chk("rst/filter_col", current_col, 4);
        chk("rst/filter_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst/ctrl", {busy, done, buffer_we}, 0);
        chk("rst/row", row_addr, 0);
        chk("rst/col", current_col, 1);
        chk("rst/kp_we", kp_bus.kp_we, 0);
        chk("rst/kp_addr", kp_bus.kp_addr, 0);
        chk("rst/kp_din", kp_bus.kp_din, 0);
        chk("rst/ovf", kp_bus.kp_overflow, 0);
`ifdef KP_COUNT_EN
        chk("rst/count", kp_count, 0);
`endif
        @(posedge clk);
        #1;
        chk("rst/kp_we_edge", kp_bus.kp_we, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst/no_write", wr_q.size(), 0);
        chk("rst/idle", busy, 0);

        random_tables();
        do_frame("post_reset", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
